// File: rtl/dmem_rmw_responder.sv
// Data-memory responder: serves byte-enabled loads/stores from a word-wide RAM
// that lacks lane write enables, merging sub-word stores by read-modify-write.
//
// state | meaning
// IDLE  | ready; loads/partial stores issue their RAM read, full-word stores write directly
// LOAD  | RAM read data arriving; captured into rsp_rdata
// MERGE | RAM read data arriving; merged lanes written back to the latched address
module dmem_rmw_responder #(
    parameter int ADR_W   = 12,
    parameter int RAM_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [ADR_W-1:0] req_adr,
    input  logic [3:0]       req_we,
    input  logic [31:0]      req_wdata,
    output logic             rsp_valid,
    output logic [31:0]      rsp_rdata,
    output logic             ram_en,
    output logic             ram_wr,
    output logic [ADR_W-1:0] ram_adr,
    output logic [31:0]      ram_wdata,
    input  logic [31:0]      ram_rdata
);

    // The LOAD/MERGE sequencing assumes read data arrives exactly one cycle after the strobe.
    if (RAM_LAT != 1) begin : g_bad_ram_lat
        $error("dmem_rmw_responder: only RAM_LAT == 1 is supported");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        MERGE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [ADR_W-1:0]   adr_q;
    logic [3:0]         we_q;
    logic [31:0]        wdata_q;
    logic               accept;
    logic               is_load;
    logic               is_full;

    assign accept  = req_valid && (state == IDLE);
    assign is_load = (req_we == 4'b0000);
    assign is_full = (req_we == 4'b1111);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            adr_q     <= '0;
            we_q      <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= (state == LOAD);
            if (state == LOAD) begin
                rsp_rdata <= ram_rdata;
            end
            if (accept && !is_full) begin
                adr_q <= req_adr;
            end
            if (accept && !is_load && !is_full) begin
                we_q    <= req_we;
                wdata_q <= req_wdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        ram_en    = 1'b0;
        ram_wr    = 1'b0;
        ram_adr   = adr_q;
        ram_wdata = wdata_q;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                ram_adr   = req_adr;
                ram_wdata = req_wdata;
                if (req_valid) begin
                    ram_en = 1'b1;
                    if (is_full) begin
                        ram_wr = 1'b1;
                    end else if (is_load) begin
                        state_nxt = LOAD;
                    end else begin
                        state_nxt = MERGE;
                    end
                end
            end
            LOAD: begin
                state_nxt = IDLE;
            end
            MERGE: begin
                ram_en = 1'b1;
                ram_wr = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    ram_wdata[8*i +: 8] = we_q[i] ? wdata_q[8*i +: 8] : ram_rdata[8*i +: 8];
                end
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_rmw_responder.sv
// Directed bench for dmem_rmw_responder: a behavioural 1-cycle RAM plus a scoreboard
// of expected RAM writes and load responses, each tagged with the cycle it must appear in.
module tb_dmem_rmw_responder;

    localparam int ADR_W = 12;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [ADR_W-1:0] req_adr = '0;
    logic [3:0]       req_we = '0;
    logic [31:0]      req_wdata = '0;
    logic             rsp_valid;
    logic [31:0]      rsp_rdata;
    logic             ram_en;
    logic             ram_wr;
    logic [ADR_W-1:0] ram_adr;
    logic [31:0]      ram_wdata;
    logic [31:0]      ram_rdata = '0;

    dmem_rmw_responder #(.ADR_W(ADR_W), .RAM_LAT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_adr   (req_adr),
        .req_we    (req_we),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_en    (ram_en),
        .ram_wr    (ram_wr),
        .ram_adr   (ram_adr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:(1<<ADR_W)-1];

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wr) mem[ram_adr] <= ram_wdata;
            else        ram_rdata    <= mem[ram_adr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ADR_W-1:0] adr;
        logic [31:0]      data;
        int               cyc;
    } exp_t;

    exp_t wq[$];
    exp_t rq[$];
    exp_t me;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: settles 1 ns after the falling edge, well clear of the rising edge.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (rsp_valid) begin
                if (rq.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    me = rq.pop_front();
                    check("rsp_rdata", rsp_rdata, me.data);
                    check("rsp_cycle", cyc, me.cyc);
                end
            end
            if (ram_en && ram_wr) begin
                if (wq.size() == 0) begin
                    check("unexpected_write", {20'd0, ram_adr}, 32'hFFFF_FFFF);
                end else begin
                    me = wq.pop_front();
                    check("write_adr", {20'd0, ram_adr}, {20'd0, me.adr});
                    check("write_data", ram_wdata, me.data);
                    check("write_cycle", cyc, me.cyc);
                end
            end
        end
    end

    // Drive a request (from posedge+1), hold until accepted, queue its expectations.
    // exp is the expected load data or merged write data; ignored for full-word stores.
    task automatic do_req(input logic [ADR_W-1:0] adr, input logic [3:0] we,
                          input logic [31:0] wdata, input logic [31:0] exp,
                          input bit expect_en, output int acc);
        exp_t e;
        req_valid = 1'b1;
        req_adr   = adr;
        req_we    = we;
        req_wdata = wdata;
        acc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else if (expect_en) begin
            e.adr = adr;
            if (we == 4'b1111) begin
                e.data = wdata; e.cyc = acc;     wq.push_back(e);
            end else if (we == 4'b0000) begin
                e.data = exp;   e.cyc = acc + 2; rq.push_back(e);
            end else begin
                e.data = exp;   e.cyc = acc + 1; wq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int a0, a1, a2, a3, c0;

    initial begin
        for (int i = 0; i < (1<<ADR_W); i++) mem[i] = '0;
        mem[12'h020] = 32'h1122_3344;
        mem[12'h021] = 32'hCAFE_F00D;
        mem[12'h030] = 32'h5555_5555;
        mem[12'h040] = 32'hA5A5_A5A5;

        #1;
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_ram_en", {31'd0, ram_en}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", {31'd0, req_ready}, 32'd1);
        idle(1);

        // SW then load of the same word
        do_req(12'h010, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b1, a0);
        do_req(12'h010, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b1, a1);
        idle(3);

        // SB lane 2, followed by a load that must wait one cycle
        do_req(12'h020, 4'b0100, 32'h00AA_0000, 32'h11AA_3344, 1'b1, a0);
        do_req(12'h020, 4'b0000, 32'h0, 32'h11AA_3344, 1'b1, a1);
        check("sb_load_accept_delay", a1 - a0, 32'd2);
        idle(3);

        // Two SH halves on the same word
        do_req(12'h021, 4'b0011, 32'h0000_1234, 32'hCAFE_1234, 1'b1, a0);
        do_req(12'h021, 4'b1100, 32'hBEEF_0000, 32'hBEEF_1234, 1'b1, a1);
        do_req(12'h021, 4'b0000, 32'h0, 32'hBEEF_1234, 1'b1, a2);
        idle(3);

        // Back-to-back SW burst with req_valid held high
        do_req(12'h000, 4'b1111, 32'h1000_0000, 32'h0, 1'b1, a0);
        do_req(12'h001, 4'b1111, 32'h1000_0001, 32'h0, 1'b1, a1);
        do_req(12'h002, 4'b1111, 32'h1000_0002, 32'h0, 1'b1, a2);
        do_req(12'h003, 4'b1111, 32'h1000_0003, 32'h0, 1'b1, a3);
        check("sw_burst_gap1", a1 - a0, 32'd1);
        check("sw_burst_gap2", a2 - a1, 32'd1);
        check("sw_burst_gap3", a3 - a2, 32'd1);
        do_req(12'h003, 4'b0000, 32'h0, 32'h1000_0003, 1'b1, a0);
        idle(3);

        // Non-contiguous mask, load presented while the merge is in flight
        do_req(12'h040, 4'b1010, 32'h1122_3344, 32'h11A5_33A5, 1'b1, a0);
        do_req(12'h040, 4'b0000, 32'h0, 32'h11A5_33A5, 1'b1, a1);
        check("merge_load_accept_delay", a1 - a0, 32'd2);
        idle(3);

        // Reset asserted during MERGE aborts the write
        do_req(12'h030, 4'b1000, 32'hAA00_0000, 32'h0, 1'b0, a0);
        rst_n = 1'b0;
        #1;
        check("rst_merge_ram_en", {31'd0, ram_en}, 32'd0);
        check("rst_merge_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_merge_rsp_rdata", rsp_rdata, 32'd0);
        idle(2);
        rst_n = 1'b1;
        check("rst_merge_ram_word", mem[12'h030], 32'h5555_5555);
        c0 = cyc;
        do_req(12'h030, 4'b0000, 32'h0, 32'h5555_5555, 1'b1, a1);
        check("accept_after_release", a1, c0);
        idle(4);

        check("pending_writes", wq.size(), 32'd0);
        check("pending_rsps", rq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
